// File: rtl/decode_rf_scoreboard.sv
// decode_rf_scoreboard
//   Decode-stage register file with write-to-read bypass and a per-register
//   pending-write scoreboard (2-bit counters, up to MAXPEND outstanding writes).
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-low reset
//   rd_sel1/2      read addresses
//   rd_en1/2       operand used by the issuing instruction (gates stall)
//   rd_data1/2     read data, bypassed from the write-back port
//   wr_en/wr_sel/wr_data   write-back port
//   issue_valid    decode attempts to issue this cycle
//   issue_wr_en    issuing instruction writes a register
//   issue_wr_sel   its destination register
//   stall          issue must not proceed this cycle (combinational)
//   busy_vec       bit i set while register i has outstanding writes
//   err            sticky protocol error (orphan write-back or counter overflow)
module decode_rf_scoreboard #(
    parameter int WIDTH   = 16,
    parameter int AW      = 3,
    parameter int MAXPEND = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       rd_sel1,
    input  logic [AW-1:0]       rd_sel2,
    input  logic                rd_en1,
    input  logic                rd_en2,
    output logic [WIDTH-1:0]    rd_data1,
    output logic [WIDTH-1:0]    rd_data2,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_sel,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                issue_valid,
    input  logic                issue_wr_en,
    input  logic [AW-1:0]       issue_wr_sel,
    output logic                stall,
    output logic [(2**AW)-1:0]  busy_vec,
    output logic                err
);

    localparam int NREGS = 2**AW;
    localparam logic [1:0] PEND_MAX = 2'(MAXPEND);

    logic [WIDTH-1:0] regs [NREGS];
    logic [1:0]       pend [NREGS];

    logic             wr_to_zero;
    logic             wr_live;
    logic             src_haz1;
    logic             src_haz2;
    logic             dst_haz;
    logic             issue_ok;
    logic             orphan_wb;
    logic [NREGS-1:0] inc;
    logic [NREGS-1:0] dec;
    logic [NREGS-1:0] ovf;

    // Writes to a hard-wired zero register are dropped entirely.
    assign wr_to_zero = (ZERO_R0 != 0) && (wr_sel == '0);
    assign wr_live    = wr_en && !wr_to_zero;

    always_comb begin
        if ((ZERO_R0 != 0) && (rd_sel1 == '0))
            rd_data1 = '0;
        else if (wr_live && (wr_sel == rd_sel1))
            rd_data1 = wr_data;
        else
            rd_data1 = regs[rd_sel1];
    end

    always_comb begin
        if ((ZERO_R0 != 0) && (rd_sel2 == '0))
            rd_data2 = '0;
        else if (wr_live && (wr_sel == rd_sel2))
            rd_data2 = wr_data;
        else
            rd_data2 = regs[rd_sel2];
    end

    // A source is only resolved by bypass when the landing write is the last
    // one outstanding; an older write landing does not carry the newest value.
    assign src_haz1 = rd_en1 && (pend[rd_sel1] != '0)
                      && !(wr_en && (wr_sel == rd_sel1) && (pend[rd_sel1] == 2'd1));
    assign src_haz2 = rd_en2 && (pend[rd_sel2] != '0)
                      && !(wr_en && (wr_sel == rd_sel2) && (pend[rd_sel2] == 2'd1));
    // A full destination counter frees a slot when a write-back lands on it now.
    assign dst_haz  = issue_wr_en && (pend[issue_wr_sel] == PEND_MAX)
                      && !(wr_en && (wr_sel == issue_wr_sel));

    assign stall    = issue_valid && (src_haz1 || src_haz2 || dst_haz);
    assign issue_ok = issue_valid && !stall;

    always_comb begin
        inc = '0;
        dec = '0;
        ovf = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            inc[i] = issue_ok && issue_wr_en && (issue_wr_sel == AW'(i));
            dec[i] = wr_en && (wr_sel == AW'(i)) && (pend[i] != '0);
            if ((ZERO_R0 != 0) && (i == 0)) begin
                inc[i] = 1'b0;
                dec[i] = 1'b0;
            end
            ovf[i] = inc[i] && !dec[i] && (pend[i] == PEND_MAX);
        end
    end

    // Write-back to a register with nothing outstanding has no matching issue.
    assign orphan_wb = wr_live && (pend[wr_sel] == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            if (wr_live)
                regs[wr_sel] <= wr_data;
            for (int unsigned i = 0; i < NREGS; i++) begin
                // An overflowing increment is flagged and the counter held.
                if (inc[i] && !dec[i] && !ovf[i])
                    pend[i] <= pend[i] + 2'd1;
                else if (dec[i] && !inc[i])
                    pend[i] <= pend[i] - 2'd1;
            end
            if (orphan_wb || (ovf != '0))
                err <= 1'b1;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int unsigned i = 0; i < NREGS; i++)
            busy_vec[i] = (pend[i] != '0);
    end

endmodule

// File: tb/tb_decode_rf_scoreboard.sv
module tb_decode_rf_scoreboard;

    logic        clk;
    logic        rst;
    logic [2:0]  rd_sel1, rd_sel2;
    logic        rd_en1, rd_en2;
    logic [15:0] rd_data1, rd_data2;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic        issue_valid, issue_wr_en;
    logic [2:0]  issue_wr_sel;
    logic        stall;
    logic [7:0]  busy_vec;
    logic        err;

    logic [15:0] z_rd_data1, z_rd_data2;
    logic        z_stall;
    logic [7:0]  z_busy_vec;
    logic        z_err;

    int n_cmp;
    int n_bad;

    decode_rf_scoreboard #(.WIDTH(16), .AW(3), .MAXPEND(3), .ZERO_R0(0)) dut (
        .clk(clk), .rst(rst),
        .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .rd_en1(rd_en1), .rd_en2(rd_en2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_wr_en(issue_wr_en), .issue_wr_sel(issue_wr_sel),
        .stall(stall), .busy_vec(busy_vec), .err(err)
    );

    decode_rf_scoreboard #(.WIDTH(16), .AW(3), .MAXPEND(3), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst),
        .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .rd_en1(rd_en1), .rd_en2(rd_en2),
        .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_wr_en(issue_wr_en), .issue_wr_sel(issue_wr_sel),
        .stall(z_stall), .busy_vec(z_busy_vec), .err(z_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_sel1 = 3'd0; rd_sel2 = 3'd0; rd_en1 = 1'b0; rd_en2 = 1'b0;
        wr_en = 1'b0; wr_sel = 3'd0; wr_data = 16'h0000;
        issue_valid = 1'b0; issue_wr_en = 1'b0; issue_wr_sel = 3'd0;
    endtask

    task automatic issue_dest(input logic [2:0] r);
        idle();
        issue_valid = 1'b1; issue_wr_en = 1'b1; issue_wr_sel = r;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        rd_sel1 = 3'd3; rd_sel2 = 3'd6;
        #1;
        n_cmp++; if (rd_data1 !== 16'h0000) begin n_bad++; $display("FAIL reset_rd1 got=%h exp=0000", rd_data1); end
        n_cmp++; if (rd_data2 !== 16'h0000) begin n_bad++; $display("FAIL reset_rd2 got=%h exp=0000", rd_data2); end
        n_cmp++; if (busy_vec !== 8'h00) begin n_bad++; $display("FAIL reset_busy got=%h exp=00", busy_vec); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    endtask

    task automatic test_write_read();
        issue_dest(3'd3);
        n_cmp++; if (busy_vec !== 8'h08) begin n_bad++; $display("FAIL wr_busy_r3 got=%h exp=08", busy_vec); end
        wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'hBEEF;
        cyc();
        idle();
        rd_sel2 = 3'd3;
        #1;
        n_cmp++; if (rd_data2 !== 16'hBEEF) begin n_bad++; $display("FAIL wr_read_r3 got=%h exp=beef", rd_data2); end
        n_cmp++; if (busy_vec !== 8'h00) begin n_bad++; $display("FAIL wr_busy_clear got=%h exp=00", busy_vec); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err got=%b exp=0", err); end
    endtask

    task automatic test_bypass();
        issue_dest(3'd5);
        wr_en = 1'b1; wr_sel = 3'd5; wr_data = 16'h1234;
        rd_sel1 = 3'd5; rd_en1 = 1'b1; issue_valid = 1'b1;
        #1;
        n_cmp++; if (rd_data1 !== 16'h1234) begin n_bad++; $display("FAIL byp_rd1 got=%h exp=1234", rd_data1); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL byp_stall got=%b exp=0", stall); end
        cyc();
        idle();
        rd_sel1 = 3'd5;
        #1;
        n_cmp++; if (rd_data1 !== 16'h1234) begin n_bad++; $display("FAIL byp_hold got=%h exp=1234", rd_data1); end
        n_cmp++; if (busy_vec !== 8'h00) begin n_bad++; $display("FAIL byp_busy got=%h exp=00", busy_vec); end
    endtask

    task automatic test_load_use();
        issue_dest(3'd2);
        n_cmp++; if (busy_vec !== 8'h04) begin n_bad++; $display("FAIL lu_busy got=%h exp=04", busy_vec); end
        issue_valid = 1'b1; rd_sel1 = 3'd2; rd_en1 = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall1 got=%b exp=1", stall); end
        rd_en1 = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_unused got=%b exp=0", stall); end
        rd_sel2 = 3'd2; rd_en2 = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall2 got=%b exp=1", stall); end
        issue_valid = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_novalid got=%b exp=0", stall); end
        issue_valid = 1'b1;
        cyc();
        n_cmp++; if (busy_vec !== 8'h04) begin n_bad++; $display("FAIL lu_busy_hold got=%h exp=04", busy_vec); end
        rd_en1 = 1'b1;
        wr_en = 1'b1; wr_sel = 3'd2; wr_data = 16'h00AA;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_wb_stall got=%b exp=0", stall); end
        n_cmp++; if (rd_data1 !== 16'h00AA) begin n_bad++; $display("FAIL lu_wb_data got=%h exp=00aa", rd_data1); end
        cyc();
        idle();
        #1;
        n_cmp++; if (busy_vec !== 8'h00) begin n_bad++; $display("FAIL lu_busy_clear got=%h exp=00", busy_vec); end
        // Instruction reading its own destination sees no hazard.
        issue_valid = 1'b1; issue_wr_en = 1'b1; issue_wr_sel = 3'd7;
        rd_sel1 = 3'd7; rd_en1 = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL own_dest_stall got=%b exp=0", stall); end
        cyc();
        idle();
        n_cmp++; if (busy_vec !== 8'h80) begin n_bad++; $display("FAIL own_dest_busy got=%h exp=80", busy_vec); end
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 16'h0777;
        cyc();
        idle();
    endtask

    task automatic test_multi_outstanding();
        issue_dest(3'd4);
        issue_dest(3'd4);
        issue_dest(3'd4);
        n_cmp++; if (busy_vec !== 8'h10) begin n_bad++; $display("FAIL mo_busy got=%h exp=10", busy_vec); end
        issue_valid = 1'b1; issue_wr_en = 1'b1; issue_wr_sel = 3'd4;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mo_full_stall got=%b exp=1", stall); end
        wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'h4441;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mo_full_wb got=%b exp=0", stall); end
        cyc();
        wr_en = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mo_still_full got=%b exp=1", stall); end
        idle();
        wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'h4442;
        cyc();
        // Two outstanding: a landing write is not the last one, so no bypass.
        issue_valid = 1'b1; rd_sel1 = 3'd4; rd_en1 = 1'b1;
        wr_data = 16'h4443;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mo_pend2_stall got=%b exp=1", stall); end
        cyc();
        n_cmp++; if (busy_vec !== 8'h10) begin n_bad++; $display("FAIL mo_busy_pend1 got=%h exp=10", busy_vec); end
        wr_data = 16'h4444;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mo_pend1_byp got=%b exp=0", stall); end
        n_cmp++; if (rd_data1 !== 16'h4444) begin n_bad++; $display("FAIL mo_pend1_data got=%h exp=4444", rd_data1); end
        cyc();
        idle();
        #1;
        n_cmp++; if (busy_vec !== 8'h00) begin n_bad++; $display("FAIL mo_drained got=%h exp=00", busy_vec); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mo_err got=%b exp=0", err); end
    endtask

    task automatic test_err_reset();
        wr_en = 1'b1; wr_sel = 3'd6; wr_data = 16'h6666;
        cyc();
        idle();
        rd_sel1 = 3'd6;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b exp=1", err); end
        n_cmp++; if (rd_data1 !== 16'h6666) begin n_bad++; $display("FAIL err_written got=%h exp=6666", rd_data1); end
        n_cmp++; if (busy_vec !== 8'h00) begin n_bad++; $display("FAIL err_busy got=%h exp=00", busy_vec); end
        cyc();
        cyc();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b exp=1", err); end
        issue_dest(3'd1);
        n_cmp++; if (busy_vec !== 8'h02) begin n_bad++; $display("FAIL err_pend_r1 got=%h exp=02", busy_vec); end
        // Issue and write-back presented during reset must be ignored.
        rst = 1'b0;
        issue_valid = 1'b1; issue_wr_en = 1'b1; issue_wr_sel = 3'd3;
        wr_en = 1'b1; wr_sel = 3'd5; wr_data = 16'h5555;
        cyc();
        rst = 1'b1;
        idle();
        rd_sel1 = 3'd6; rd_sel2 = 3'd5;
        #1;
        n_cmp++; if (busy_vec !== 8'h00) begin n_bad++; $display("FAIL rst_busy got=%h exp=00", busy_vec); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", err); end
        n_cmp++; if (rd_data1 !== 16'h0000) begin n_bad++; $display("FAIL rst_r6 got=%h exp=0000", rd_data1); end
        n_cmp++; if (rd_data2 !== 16'h0000) begin n_bad++; $display("FAIL rst_r5 got=%h exp=0000", rd_data2); end
    endtask

    task automatic test_zero_r0();
        idle();
        wr_en = 1'b1; wr_sel = 3'd0; wr_data = 16'hFFFF;
        rd_sel1 = 3'd0;
        #1;
        n_cmp++; if (z_rd_data1 !== 16'h0000) begin n_bad++; $display("FAIL z_nobypass got=%h exp=0000", z_rd_data1); end
        cyc();
        idle();
        issue_valid = 1'b1; issue_wr_en = 1'b1; issue_wr_sel = 3'd0;
        rd_sel1 = 3'd0; rd_en1 = 1'b1; rd_sel2 = 3'd0; rd_en2 = 1'b1;
        #1;
        n_cmp++; if (z_rd_data2 !== 16'h0000) begin n_bad++; $display("FAIL z_rd2 got=%h exp=0000", z_rd_data2); end
        n_cmp++; if (z_err !== 1'b0) begin n_bad++; $display("FAIL z_err_wr got=%b exp=0", z_err); end
        cyc();
        n_cmp++; if (z_busy_vec !== 8'h00) begin n_bad++; $display("FAIL z_busy got=%h exp=00", z_busy_vec); end
        n_cmp++; if (z_stall !== 1'b0) begin n_bad++; $display("FAIL z_stall got=%b exp=0", z_stall); end
        n_cmp++; if (z_rd_data1 !== 16'h0000) begin n_bad++; $display("FAIL z_rd1 got=%h exp=0000", z_rd_data1); end
        n_cmp++; if (z_err !== 1'b0) begin n_bad++; $display("FAIL z_err got=%b exp=0", z_err); end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_load_use();
        test_multi_outstanding();
        test_err_reset();
        test_zero_r0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
